// File: rtl/post_neuron.sv
// post_neuron: integrate-and-fire neuron at the receiving end of a synapse row.
// It adds the excitatory and inhibitory synapse bits into a saturating membrane
// potential that loses LEAK each cycle. On a threshold crossing it drives a
// multi-cycle post_out pulse to the synapses and then sits out a refractory
// period.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_INTEG  | integrating synapse input; inhibit clears, en gates update
// S_FIRE   | post_out high for PULSE_LEN cycles, inputs ignored
// S_REFRAC | refractory hold for REFRAC_LEN cycles, inputs ignored
module post_neuron #(
    parameter int N_SYN      = 16,
    parameter int VW         = 12,
    parameter int THRESH     = 8,
    parameter int LEAK       = 1,
    parameter int PULSE_LEN  = 3,
    parameter int REFRAC_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_SYN-1:0] weight_up,
    input  logic [N_SYN-1:0] weight_down,
    input  logic             inhibit,
    output logic             post_out,
    output logic             spike,
    output logic [VW-1:0]    v_mem,
    output logic             busy
);

    localparam int CW = $clog2(N_SYN + 1);
    localparam int SW = VW + 2;

    localparam logic [2:0] S_INTEG  = 3'b001;
    localparam logic [2:0] S_FIRE   = 3'b010;
    localparam logic [2:0] S_REFRAC = 3'b100;

    // The counter is loaded with length-1 and the phase ends at zero.
    localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_LEN - 1);
    localparam logic [7:0] REFRAC_LOAD = (REFRAC_LEN == 0) ? 8'd0 : 8'(REFRAC_LEN - 1);
    localparam logic [VW-1:0] THRESH_V = VW'(THRESH);

    logic [2:0]           state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [VW-1:0]        v_q, v_d;
    logic [CW-1:0]        up_cnt, dn_cnt;
    logic signed [SW-1:0] sum;
    logic [VW-1:0]        v_next;

    // Count the active synapse bits on each side.
    always_comb begin
        up_cnt = '0;
        dn_cnt = '0;
        for (int i = 0; i < N_SYN; i++) begin
            up_cnt = up_cnt + CW'(weight_up[i]);
            dn_cnt = dn_cnt + CW'(weight_down[i]);
        end
    end

    // Signed candidate potential, clamped to [0, 2^VW-1] with no wrap-around.
    always_comb begin
        sum = $signed(SW'(v_q)) + $signed(SW'(up_cnt))
            - $signed(SW'(dn_cnt)) - $signed(SW'(LEAK));
        if (sum[SW-1]) begin
            v_next = '0;
        end else if (|sum[SW-2:VW]) begin
            v_next = '1;
        end else begin
            v_next = sum[VW-1:0];
        end
    end

    // State, counter and potential registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INTEG;
            cnt_q   <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
        end
    end

    // Next-state logic. Inhibit wins over firing in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        case (state_q)
            S_INTEG: begin
                if (inhibit) begin
                    v_d = '0;
                end else if (en) begin
                    if (v_next >= THRESH_V) begin
                        v_d     = '0;
                        cnt_d   = PULSE_LOAD;
                        state_d = S_FIRE;
                    end else begin
                        v_d = v_next;
                    end
                end
            end
            S_FIRE: begin
                v_d = '0;
                if (cnt_q == 8'd0) begin
                    if (REFRAC_LEN == 0) begin
                        state_d = S_INTEG;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = S_REFRAC;
                        cnt_d   = REFRAC_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_REFRAC: begin
                v_d = '0;
                if (cnt_q == 8'd0) begin
                    state_d = S_INTEG;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = S_INTEG;
                cnt_d   = 8'd0;
                v_d     = '0;
            end
        endcase
    end

    // Outputs decoded from registered state. Spike marks the first FIRE
    // cycle, which is the only one with the counter still at its load value.
    always_comb begin
        post_out = 1'b0;
        spike    = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_FIRE: begin
                post_out = 1'b1;
                busy     = 1'b1;
                spike    = (cnt_q == PULSE_LOAD);
            end
            S_REFRAC: begin
                busy = 1'b1;
            end
            default: begin
                post_out = 1'b0;
            end
        endcase
        v_mem = v_q;
    end

endmodule

// File: tb/tb_post_neuron.sv
// tb_post_neuron: two neuron instances (default sizing, and a narrow
// saturating one with no refractory period) share one stimulus stream and are
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_post_neuron;

    logic        clk = 1'b0;
    logic        rst, en, inh;
    logic [15:0] up, dn;

    logic        post0, spike0, busy0;
    logic [11:0] v0;
    logic        post1, spike1, busy1;
    logic [3:0]  v1;

    post_neuron #(.N_SYN(16), .VW(12), .THRESH(8), .LEAK(1),
                  .PULSE_LEN(3), .REFRAC_LEN(4)) dut0 (
        .clk(clk), .rst(rst), .en(en), .weight_up(up), .weight_down(dn),
        .inhibit(inh), .post_out(post0), .spike(spike0), .v_mem(v0), .busy(busy0)
    );

    post_neuron #(.N_SYN(16), .VW(4), .THRESH(15), .LEAK(1),
                  .PULSE_LEN(3), .REFRAC_LEN(0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .weight_up(up), .weight_down(dn),
        .inhibit(inh), .post_out(post1), .spike(spike1), .v_mem(v1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: potential, and cycles elapsed since the fire event (-1 = idle).
    int m_v[2]    = '{0, 0};
    int m_el[2]   = '{-1, -1};
    int p_th[2]   = '{8, 15};
    int p_vmax[2] = '{4095, 15};
    int p_busy[2] = '{7, 3};
    localparam int PL = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int s;
        if (rst) begin
            m_v[k]  = 0;
            m_el[k] = -1;
        end else if (m_el[k] >= 0) begin
            m_el[k]++;
            if (m_el[k] >= p_busy[k]) m_el[k] = -1;
            m_v[k] = 0;
        end else if (inh) begin
            m_v[k] = 0;
        end else if (en) begin
            s = m_v[k] + $countones(up) - $countones(dn) - 1;
            if (s < 0) s = 0;
            if (s > p_vmax[k]) s = p_vmax[k];
            if (s >= p_th[k]) begin
                m_v[k]  = 0;
                m_el[k] = 0;
            end else begin
                m_v[k] = s;
            end
        end
    endtask

    // Advance the model on each edge and compare both instances just after it.
    always begin
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("d0_v",     32'(v0),     32'(m_v[0]));
        check("d0_post",  32'(post0),  32'(m_el[0] >= 0 && m_el[0] < PL));
        check("d0_spike", 32'(spike0), 32'(m_el[0] == 0));
        check("d0_busy",  32'(busy0),  32'(m_el[0] >= 0));
        check("d1_v",     32'(v1),     32'(m_v[1]));
        check("d1_post",  32'(post1),  32'(m_el[1] >= 0 && m_el[1] < PL));
        check("d1_spike", 32'(spike1), 32'(m_el[1] == 0));
        check("d1_busy",  32'(busy1),  32'(m_el[1] >= 0));
    end

    task automatic step(input logic r, input logic e, input logic [15:0] u,
                        input logic [15:0] d, input logic i);
        @(negedge clk);
        rst = r; en = e; up = u; dn = d; inh = i;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic        r_r, r_e, r_i;
        logic [15:0] r_u, r_d;
        rst = 1'b1; en = 1'b1; up = 16'hFFFF; dn = 16'h0; inh = 1'b0;

        // Reset held with all excitatory inputs active
        for (int k = 0; k < 2; k++) begin
            step(1, 1, 16'hFFFF, 16'h0, 0);
            check("rst_post", 32'(post0), 0);
            check("rst_spike", 32'(spike0), 0);
            check("rst_busy", 32'(busy0), 0);
            check("rst_v", 32'(v0), 0);
        end

        // Threshold fire: 3, 6, then 6+4-1=9 fires
        step(0, 1, 16'h000F, 16'h0, 0); check("fire_v3", 32'(v0), 3);
        step(0, 1, 16'h000F, 16'h0, 0); check("fire_v6", 32'(v0), 6);
        step(0, 1, 16'h000F, 16'h0, 0);
        check("fire_spike", 32'(spike0), 1);
        check("fire_post", 32'(post0), 1);
        check("fire_busy", 32'(busy0), 1);
        check("fire_v0", 32'(v0), 0);
        for (int k = 1; k < 7; k++) begin
            step(0, 1, 16'h000F, 16'h0, 0);
            check("busy_spike", 32'(spike0), 0);
            check("busy_post", 32'(post0), 32'(k < 3));
            check("busy_busy", 32'(busy0), 1);
            check("busy_v", 32'(v0), 0);
        end
        step(0, 1, 16'h000F, 16'h0, 0);
        check("idle_busy", 32'(busy0), 0);
        check("idle_v", 32'(v0), 0);
        step(0, 1, 16'h000F, 16'h0, 0); check("resume_v3", 32'(v0), 3);

        // Leak down to the floor without wrapping
        step(0, 1, 16'h0, 16'h0, 1);    check("inh_clr", 32'(v0), 0);
        step(0, 1, 16'h007F, 16'h0, 0); check("load6", 32'(v0), 6);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 16'h0, 16'h0, 0);
            check("leak", 32'(v0), 32'((5 - k < 0) ? 0 : 5 - k));
        end
        step(0, 1, 16'h007F, 16'h0, 0);    check("reload6", 32'(v0), 6);
        step(0, 1, 16'hFFFF, 16'hFFFF, 0); check("cancel5", 32'(v0), 5);
        step(0, 1, 16'hFFFF, 16'hFFFF, 0); check("cancel4", 32'(v0), 4);

        // Inhibit beats threshold, and does not cut a pulse short
        step(0, 1, 16'h0, 16'h0, 1);
        step(0, 1, 16'h007F, 16'h0, 0);
        step(0, 1, 16'h000F, 16'h0, 1);
        check("inhp_v", 32'(v0), 0);
        check("inhp_spike", 32'(spike0), 0);
        check("inhp_post", 32'(post0), 0);
        step(0, 1, 16'h000F, 16'h0, 0);
        step(0, 1, 16'h000F, 16'h0, 0);
        step(0, 1, 16'h000F, 16'h0, 0); check("inhf_spike", 32'(spike0), 1);
        step(0, 1, 16'h000F, 16'h0, 1); check("inhf_post1", 32'(post0), 1);
        step(0, 1, 16'h000F, 16'h0, 1); check("inhf_post2", 32'(post0), 1);
        step(0, 1, 16'h0, 16'h0, 1);
        check("inhf_post_end", 32'(post0), 0);
        check("inhf_refrac", 32'(busy0), 1);
        for (int k = 0; k < 4; k++) step(0, 1, 16'h0, 16'h0, 0);
        check("inhf_done", 32'(busy0), 0);

        // Reset during the second FIRE cycle
        step(0, 1, 16'h000F, 16'h0, 0);
        step(0, 1, 16'h000F, 16'h0, 0);
        step(0, 1, 16'h000F, 16'h0, 0); check("mid_spike", 32'(spike0), 1);
        step(0, 1, 16'h000F, 16'h0, 0); check("mid_post", 32'(post0), 1);
        step(1, 1, 16'h000F, 16'h0, 0);
        check("mid_rst_post", 32'(post0), 0);
        check("mid_rst_busy", 32'(busy0), 0);
        check("mid_rst_v", 32'(v0), 0);
        step(0, 1, 16'h000F, 16'h0, 0); check("mid_resume", 32'(v0), 3);

        // en=0 holds the potential and blocks firing
        step(0, 1, 16'h000F, 16'h0, 0); check("en_load", 32'(v0), 6);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 16'hFFFF, 16'h0, 0);
            check("en_hold", 32'(v0), 6);
            check("en_nospike", 32'(spike0), 0);
        end

        // Narrow instance: saturating fire, no refractory period
        step(0, 1, 16'h0, 16'h0, 1);
        step(0, 1, 16'hFFFF, 16'h0, 0);
        check("sat_spike", 32'(spike1), 1);
        check("sat_v", 32'(v1), 0);
        step(0, 1, 16'hFFFF, 16'h0, 0); check("sat_post1", 32'(post1), 1);
        step(0, 1, 16'hFFFF, 16'h0, 0); check("sat_post2", 32'(busy1), 1);
        step(0, 1, 16'hFFFF, 16'h0, 0); check("sat_norefrac", 32'(busy1), 0);
        step(0, 1, 16'hFFFF, 16'h0, 0); check("sat_refire", 32'(spike1), 1);

        // Randomized traffic, checked by the per-cycle model
        for (int c = 0; c < 4000; c++) begin
            r_r = ($urandom_range(0, 299) == 0);
            r_e = ($urandom_range(0, 7) != 0);
            r_i = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0: begin r_u = 16'($urandom); r_d = 16'($urandom); end
                1: begin r_u = 16'($urandom & $urandom); r_d = 16'($urandom & $urandom & $urandom); end
                2: begin r_u = 16'($urandom & $urandom & $urandom); r_d = 16'($urandom & $urandom); end
                default: begin r_u = 16'hFFFF; r_d = 16'($urandom & $urandom & $urandom & $urandom); end
            endcase
            step(r_r, r_e, r_u, r_d, r_i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/post_neuron.md
Name: post_neuron

Overview:
- Postsynaptic integrate-and-fire neuron: the receiving end of a synapse row.
- Sums `weight_up` / `weight_down` from N_SYN synapse instances into a membrane potential with linear leak.
- On threshold crossing, emits a `post_out` pulse wide enough for the synapse learning FSMs to see (≥3 cycles); this pulse drives every synapse's `post_in`.
- `inhibit` input provides winner-take-all lateral inhibition from sibling neurons.

Parameters:
- N_SYN, 16: number of synapse inputs.
- VW, 12: membrane potential width, unsigned.
- THRESH, 8: firing threshold; fire when v_next >= THRESH.
- LEAK, 1: constant subtracted every integrating cycle.
- PULSE_LEN, 3: `post_out` high time in cycles; legal range 3..255.
- REFRAC_LEN, 4: refractory cycles after the pulse; legal range 0..255.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  integration enable; when 0, v_mem holds and no new fire starts (FIRE/REFRAC still count down)
- weight_up  in  N_SYN  excitatory bits, one per synapse
- weight_down  in  N_SYN  inhibitory bits, one per synapse
- inhibit  in  1  lateral inhibition; clears potential
- post_out  out  1  postsynaptic pulse to synapse `post_in`
- spike  out  1  one-cycle strobe marking the fire event
- v_mem  out  VW  current membrane potential
- busy  out  1  high in FIRE or REFRAC

Behaviour:
- Reset (rst=1 at an edge): state=INTEG, v_mem=0, post_out=0, spike=0, busy=0, counter=0. Reset has priority in every state, including mid-FIRE and mid-REFRAC.
- Arithmetic, per cycle:
  - up_cnt = popcount(weight_up), dn_cnt = popcount(weight_down), each width clog2(N_SYN+1).
  - A bit set in both vectors counts once in each, so net 0.
  - sum = v_mem + up_cnt − dn_cnt − LEAK, computed signed with VW+2 bits.
  - v_next = 0 if sum<0; 2^VW−1 if sum>2^VW−1; else sum. There is no wrap-around.
- State INTEG:
  - If inhibit=1: v_mem<=0, stay INTEG. Inhibit beats threshold in the same cycle; no spike.
  - Else if en=0: hold v_mem.
  - Else if v_next>=THRESH: v_mem<=0, post_out<=1, spike<=1, busy<=1, counter<=PULSE_LEN−1, go FIRE.
  - Else: v_mem<=v_next.
- Latency: inputs sampled at edge k cause post_out/spike high from edge k (visible cycle k+1).
- State FIRE:
  - post_out=1; spike=1 only in the first FIRE cycle.
  - Inputs and inhibit are ignored; v_mem stays 0.
  - When counter=0: post_out<=0; go REFRAC with counter<=REFRAC_LEN−1, or go INTEG directly if REFRAC_LEN=0. Otherwise decrement the counter.
- State REFRAC:
  - post_out=0, v_mem=0, inputs and inhibit ignored.
  - When counter=0: busy<=0, go INTEG. Otherwise decrement the counter.
- Total busy time: exactly PULSE_LEN+REFRAC_LEN cycles. First integration resumes on the cycle after busy falls.
- FSM encoding: one-hot, 3 states. Illegal state → INTEG with v_mem=0.

Test Plan:
- Reset check: rst high 2 cycles with weight_up=16'hFFFF → post_out=0, spike=0, busy=0, v_mem=0 throughout; first integration occurs on the cycle after rst falls.
- Threshold fire: weight_up=16'h000F held, down=0, en=1 → v_mem 3, 6, then fire on the 3rd edge (6+4−1=9≥8). Then:
  - spike high 1 cycle; post_out high exactly 3 cycles; busy high 7 cycles; v_mem=0;
  - input ignored during busy; integration restarts with v_mem=3 on the cycle after busy falls.
- Leak and floor: load v_mem=6 (up=16'h007F for 1 cycle), then inputs 0 → v_mem 5,4,3,2,1,0,0 and stays 0, never wraps. Also up=16'hFFFF with down=16'hFFFF → v_mem decays as if no input.
- Inhibit priority: v_mem=6, apply up=16'h000F with inhibit=1 in the same cycle → no spike, post_out stays 0, v_mem=0. Inhibit asserted during FIRE → pulse completes unaffected.
- Reset mid-pulse: assert rst on the 2nd FIRE cycle → next edge post_out=0, busy=0, state INTEG, v_mem=0.
- Saturation / en: VW=4, THRESH=15 override, up=16'hFFFF → v_mem clamps to 15 and fires. With en=0 and any input, v_mem holds its value and no spike occurs.
